cam_pattern_gen: RTL and testbench
==================================

# cam_pattern_gen

- Synthesizable OV7670-style sensor emulator: drives the same vsync/href/8-bit data stream the camera drives into the capture path, using selectable test patterns.
- Drops in place of the physical camera, with its clock forwarded as pixel clock, for bring-up, loopback and regression of capture → output FIFO → downstream.
- Emits RGB444 pixels as two bytes per pixel with VGA-like frame timing.

## Interface
Parameters:
- ACTIVE_W, 640, active pixels per line; must be a multiple of 8
- ACTIVE_H, 480, active lines per frame
- H_BLANK, 288, byte-clocks with href low after each line's active bytes
- VSYNC_LINES, 3, lines with vsync high
- VBP_LINES, 17, blank lines after vsync
- VFP_LINES, 10, blank lines after the last active line

Ports:
- i_clk, in, 1, single clock, doubling as forwarded pclk
- i_rst, in, 1, synchronous active-high reset
- i_en, in, 1, level; run frames continuously while high
- i_mode, in, 2, pattern select: 0 bars, 1 gradient, 2 checker, 3 count
- o_vsync, out, 1, active-high frame sync
- o_href, out, 1, active-high line-data qualifier
- o_data, out, 8, pixel byte
- o_sof, out, 1, one-cycle pulse on the first vsync-high cycle
- o_frame_done, out, 1, one-cycle pulse on the last VFP cycle
- o_busy, out, 1, high whenever state != IDLE
- o_frame_cnt, out, 16, completed frames, wraps

## Operation
- H_TOTAL = 2*ACTIVE_W + H_BLANK byte-clocks per line. The horizontal counter hcnt runs 0..H_TOTAL-1 in every non-IDLE state.
- State machine: IDLE → VSYNC (VSYNC_LINES lines) → VBP (VBP_LINES lines) → ACTIVE (ACTIVE_H lines) → VFP (VFP_LINES lines).
  - At the end of VFP: if i_en is high, go to VSYNC; otherwise go to IDLE.
  - Transitions occur at hcnt = H_TOTAL-1 of the last line of each state.
- IDLE → VSYNC when i_en is sampled high. Deasserting i_en mid-frame never truncates the frame.
- i_mode is latched on entry to VSYNC and held constant for the whole frame.
- o_vsync = 1 only in VSYNC.
- o_href = 1 only in ACTIVE with hcnt < 2*ACTIVE_W.
- o_data = 0 whenever o_href = 0.
- Pixel coordinates: x = hcnt>>1, y = active line index. Byte 0 = {4'h0, R}, byte 1 = {G, B}.
- Patterns, as 12-bit RGB:
  - Mode 0, bars: 8 bars, each ACTIVE_W/8 wide, tracked with a bar counter (no divider). Colors in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Mode 1, gradient: R = G = B = x[7:4].
  - Mode 2, checker: FFF if x[4]^y[4], else 000.
  - Mode 3, count: a 12-bit pixel counter loaded with o_frame_cnt[11:0] at VSYNC entry, incremented after each pixel, wrapping mod 4096.
- o_frame_cnt increments in the o_frame_done cycle.

## Timing
- All outputs registered. Reset value of every output is 0.
- i_rst has priority over everything. Mid-frame reset: the next cycle is IDLE with all outputs 0, and the frame is abandoned with no o_frame_done.
- i_en sampled high in IDLE at cycle N → o_vsync = 1 and o_sof = 1 at N+1.
- o_vsync stays high for exactly VSYNC_LINES*H_TOTAL cycles.
- First o_href high begins exactly (VSYNC_LINES+VBP_LINES)*H_TOTAL cycles after the first vsync cycle.
- Each href pulse lasts 2*ACTIVE_W cycles and is followed by H_BLANK low cycles.
- Frame period = (VSYNC_LINES+VBP_LINES+ACTIVE_H+VFP_LINES)*H_TOTAL cycles.
- Back-to-back frames: a new o_sof directly follows o_frame_done with no gap.
- o_data is stable for the full cycle, so a consumer sampling on the rising edge sees each byte once.
- Counter widths are $clog2 of their maximum value plus 1. No overflow occurs within any legal parameter set.

## Structure
- Shared package cam_pkg holds:
  - state enum (IDLE, VSYNC, VBP, ACTIVE, VFP)
  - mode encodings
  - the 8 bar-color RGB444 constants
- One sub-module, cam_pattern_px: registered pixel generator taking mode, x, y, bar index and count, and producing 12-bit RGB.
- The top-level cam_pattern_gen holds the timing FSM and counters, and serializes pixels into bytes.

## Test plan
Sim parameters: ACTIVE_W=16, ACTIVE_H=4, H_BLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, giving H_TOTAL=36 and a frame of 252 cycles.
- Reset, then i_en=0 for 100 cycles → all outputs stay 0 and o_busy=0.
- i_en pulsed for one cycle, mode 0 → o_sof at N+1 and vsync high for 36 cycles. First href at cycle offset 72, 4 lines of 32 bytes. Byte pairs: 0F,FF ×2; 0F,F0 ×2; … 00,00. Then o_frame_done, o_frame_cnt=1, return to IDLE.
- i_en held high, mode 3, 3 frames → frames are contiguous. Frame k's first pixel is {0,k}, incrementing by 1 per pixel for 64 pixels. o_frame_cnt reaches 3.
- i_mode changed from 2 to 1 mid-frame → current frame completes as checker; next frame is gradient.
- i_rst asserted during ACTIVE line 2 → next cycle all outputs 0, o_frame_cnt=0, no o_frame_done.
- i_en dropped during VBP → frame completes normally, then IDLE. Loopback through capture and the output FIFO recovers identical 12-bit pixels.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera pattern generator.
//   cam_state_e : frame timing FSM states
//   cam_mode_e  : test pattern select encodings (i_mode)
//   BAR_*       : RGB444 colours of the eight vertical bars, left to right
//   bar_color() : bar index -> RGB444
package cam_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StActive,
    StVfp
  } cam_state_e;

  typedef enum logic [1:0] {
    ModeBars     = 2'd0,
    ModeGradient = 2'd1,
    ModeChecker  = 2'd2,
    ModeCount    = 2'd3
  } cam_mode_e;

  // Width of the pixel coordinates handed to the pixel generator.
  localparam int unsigned COORD_W = 16;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    unique case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pattern_px.sv
// Registered pixel generator: one cycle after the inputs are presented, o_rgb holds
// the RGB444 colour of pixel (i_x, i_y) for the selected pattern.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_mode       : pattern select
//   i_x, i_y     : pixel coordinates
//   i_bar        : bar index of pixel i_x (bars pattern)
//   i_count      : running pixel count (count pattern)
//   o_rgb        : {R, G, B}, 4 bits each
module cam_pattern_px
  import cam_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  cam_mode_e          i_mode,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [2:0]         i_bar,
  input  logic [11:0]        i_count,
  output logic [11:0]        o_rgb
);

  logic [11:0] rgb_d;

  // Only x[7:4] and y[4] feed any pattern.
  logic unused_coord;
  assign unused_coord = ^{i_x[COORD_W-1:8], i_x[3:0], i_y[COORD_W-1:5], i_y[3:0]};

  always_comb begin
    rgb_d = 12'h000;
    unique case (i_mode)
      ModeBars:     rgb_d = bar_color(i_bar);
      ModeGradient: rgb_d = {3{i_x[7:4]}};
      ModeChecker:  rgb_d = (i_x[4] ^ i_y[4]) ? 12'hFFF : 12'h000;
      ModeCount:    rgb_d = i_count;
      default:      rgb_d = 12'h000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rgb <= '0;
    end else begin
      o_rgb <= rgb_d;
    end
  end

endmodule

// File: rtl/cam_pattern_gen.sv
// OV7670-style sensor emulator: produces vsync/href/8-bit data with VGA-like frame
// timing and RGB444 test patterns, two bytes per pixel ({0,R} then {G,B}).
//   i_clk        : clock, also the forwarded pixel clock
//   i_rst        : synchronous active-high reset
//   i_en         : run frames continuously while high; a started frame always completes
//   i_mode       : pattern (0 bars, 1 gradient, 2 checker, 3 count), latched per frame
//   o_vsync      : high during the vsync lines
//   o_href       : high while active-line bytes are on o_data
//   o_data       : pixel byte, zero outside href
//   o_sof        : pulse on the first vsync cycle
//   o_frame_done : pulse on the last cycle of the frame
//   o_busy       : high whenever a frame is in progress
//   o_frame_cnt  : completed frames, wrapping
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int unsigned ACTIVE_W    = 640,
  parameter int unsigned ACTIVE_H    = 480,
  parameter int unsigned H_BLANK     = 288,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 17,
  parameter int unsigned VFP_LINES   = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [1:0]  i_mode,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_frame_done,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL   = 2 * ACTIVE_W + H_BLANK;
  localparam int unsigned HW        = $clog2(H_TOTAL) + 1;
  localparam int unsigned MAX_A     = (ACTIVE_H > VBP_LINES) ? ACTIVE_H : VBP_LINES;
  localparam int unsigned MAX_B     = (VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES;
  localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned LW        = $clog2(MAX_LINES) + 1;
  localparam int unsigned BAR_PX    = ACTIVE_W / 8;
  localparam int unsigned BW        = $clog2(BAR_PX) + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PREV   = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT    = HW'(2 * ACTIVE_W);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] ACT_LAST = LW'(ACTIVE_H - 1);
  localparam logic [LW-1:0] VFP_LAST = LW'(VFP_LINES - 1);
  localparam logic [BW-1:0] SUB_LAST = BW'(BAR_PX - 1);

  cam_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] line_q, line_d;
  logic          line_end, frame_start;

  cam_mode_e     mode_q;
  logic [2:0]    bar_q, bar_d;
  logic [BW-1:0] sub_q, sub_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [11:0]   rgb;

  logic [HW-1:0] la_pos;
  logic          la_wrap, la_active;
  logic [LW-1:0] la_y;

  logic          vsync_d, href_d, sof_d, done_d, busy_d;
  logic [7:0]    data_d;
  logic [15:0]   frame_cnt_d;

  assign line_end    = (hcnt_q == H_LAST);
  assign frame_start = (state_d == StVsync) && (state_q != StVsync);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      line_q  <= line_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    hcnt_d  = '0;
    if (state_q != StIdle) hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d = StVsync;
          line_d  = '0;
        end
      end
      StVsync: begin
        if (line_end) begin
          line_d = line_q + 1'b1;
          if (line_q == VS_LAST) begin
            state_d = StVbp;
            line_d  = '0;
          end
        end
      end
      StVbp: begin
        if (line_end) begin
          line_d = line_q + 1'b1;
          if (line_q == VBP_LAST) begin
            state_d = StActive;
            line_d  = '0;
          end
        end
      end
      StActive: begin
        if (line_end) begin
          line_d = line_q + 1'b1;
          if (line_q == ACT_LAST) begin
            state_d = StVfp;
            line_d  = '0;
          end
        end
      end
      StVfp: begin
        if (line_end) begin
          line_d = line_q + 1'b1;
          if (line_q == VFP_LAST) begin
            state_d = i_en ? StVsync : StIdle;
            line_d  = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = '0;
      end
    endcase
  end

  // Pixel look-ahead: outputs are registered from next-state values and the pixel
  // generator adds a register, so pixel data is requested for the byte position two
  // cycles ahead of the one currently on the outputs. Needs H_BLANK >= 2.
  always_comb begin
    la_wrap   = (hcnt_q >= H_PREV);
    la_pos    = la_wrap ? (hcnt_q - H_PREV) : (hcnt_q + HW'(2));
    la_active = la_wrap ? (((state_q == StVbp) && (line_q == VBP_LAST)) ||
                           ((state_q == StActive) && (line_q != ACT_LAST)))
                        : (state_q == StActive);
    la_y      = la_wrap ? ((state_q == StActive) ? line_q + 1'b1 : '0) : line_q;

    // Bar tracking restarts in every blanking interval and steps after each pixel.
    bar_d = bar_q;
    sub_d = sub_q;
    if (la_pos >= H_ACT) begin
      bar_d = '0;
      sub_d = '0;
    end else if (la_pos[0]) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        bar_d = bar_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    cnt_d = cnt_q;
    if (frame_start) begin
      cnt_d = frame_cnt_d[11:0];
    end else if (la_active && la_pos[0] && (la_pos < H_ACT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q <= ModeBars;
      bar_q  <= '0;
      sub_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (frame_start) mode_q <= cam_mode_e'(i_mode);
      bar_q <= bar_d;
      sub_q <= sub_d;
      cnt_q <= cnt_d;
    end
  end

  cam_pattern_px u_px (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_mode  (mode_q),
    .i_x     (COORD_W'(la_pos >> 1)),
    .i_y     (COORD_W'(la_y)),
    .i_bar   (bar_q),
    .i_count (cnt_q),
    .o_rgb   (rgb)
  );

  // Outputs, computed for the position entered at the next edge
  always_comb begin
    vsync_d     = (state_d == StVsync);
    href_d      = (state_d == StActive) && (hcnt_d < H_ACT);
    data_d      = 8'h00;
    if (href_d) data_d = hcnt_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    sof_d       = frame_start;
    done_d      = (state_d == StVfp) && (line_d == VFP_LAST) && (hcnt_d == H_LAST);
    busy_d      = (state_d != StIdle);
    frame_cnt_d = o_frame_cnt + {15'd0, done_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_data       <= '0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_vsync      <= vsync_d;
      o_href       <= href_d;
      o_data       <= data_d;
      o_sof        <= sof_d;
      o_frame_done <= done_d;
      o_busy       <= busy_d;
      o_frame_cnt  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
module tb_cam_pattern_gen;

  localparam int W     = 16;
  localparam int AH    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int HT    = 2 * W + HB;
  localparam int FRAME = (VS + VBP + AH + VFP) * HT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        vsync, href, sof, frame_done, busy;
  logic [7:0]  data;
  logic [15:0] frame_cnt;
  logic [28:0] dut_vec;

  int tests_run = 0;
  int tests_failed = 0;
  int model_fc = 0;

  always #5 clk = ~clk;

  cam_pattern_gen #(
    .ACTIVE_W    (W),
    .ACTIVE_H    (AH),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .VBP_LINES   (VBP),
    .VFP_LINES   (VFP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_mode       (mode),
    .o_vsync      (vsync),
    .o_href       (href),
    .o_data       (data),
    .o_sof        (sof),
    .o_frame_done (frame_done),
    .o_busy       (busy),
    .o_frame_cnt  (frame_cnt)
  );

  assign dut_vec = {vsync, href, sof, frame_done, busy, data, frame_cnt};

  // Reference pattern colour from the pattern definitions.
  function automatic logic [11:0] ref_rgb(input int m, input int x, input int y, input int cnt);
    logic [11:0] bars [8];
    int v;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    case (m)
      0: return bars[x / (W / 8)];
      1: begin
        v = (x >> 4) & 15;
        return {v[3:0], v[3:0], v[3:0]};
      end
      2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: begin
        v = cnt & 12'hFFF;
        return v[11:0];
      end
    endcase
  endfunction

  // Expected {vsync, href, sof, done, busy, data, frame_cnt} at frame offset c.
  function automatic logic [28:0] exp_out(input int m, input int fc, input int c);
    int line, h, act, x;
    logic hr;
    logic [11:0] rgb;
    logic [7:0] d;
    logic [15:0] fcnt;
    line = c / HT;
    h    = c % HT;
    act  = line - (VS + VBP);
    hr   = (act >= 0) && (act < AH) && (h < 2 * W);
    d    = 8'h00;
    if (hr) begin
      x   = h / 2;
      rgb = ref_rgb(m, x, act, fc + act * W + x);
      d   = (h % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
    end
    fcnt = (c == FRAME - 1) ? 16'(fc + 1) : 16'(fc);
    return {line < VS, hr, c == 0, c == FRAME - 1, 1'b1, d, fcnt};
  endfunction

  function automatic logic [28:0] idle_out(input int fc);
    return {5'b0, 8'h00, 16'(fc)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_fc = 0;
    @(negedge clk);
    tests_run++;
    if (dut_vec !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset: got %h want %h", dut_vec, 29'd0);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== idle_out(model_fc)) begin
        tests_failed++;
        $display("FAIL idle cyc %0d: got %h want %h", i, dut_vec, idle_out(model_fc));
      end
    end
  endtask

  task automatic test_bars_single();
    @(posedge clk);
    #1 mode = 2'd0;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== exp_out(0, model_fc, c)) begin
        tests_failed++;
        $display("FAIL bars off %0d: got %h want %h", c, dut_vec, exp_out(0, model_fc, c));
      end
    end
    model_fc++;
    @(negedge clk);
    tests_run++;
    if (dut_vec !== idle_out(model_fc)) begin
      tests_failed++;
      $display("FAIL bars_to_idle: got %h want %h", dut_vec, idle_out(model_fc));
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_fc = 0;
    mode = 2'd3;
    en = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        tests_run++;
        if (dut_vec !== exp_out(3, model_fc, c)) begin
          tests_failed++;
          $display("FAIL b2b f%0d off %0d: got %h want %h", f, c, dut_vec,
                   exp_out(3, model_fc, c));
        end
        if (f == 2 && c == 10) en = 1'b0;
      end
      model_fc++;
    end
    @(negedge clk);
    tests_run++;
    if (frame_cnt !== 16'd3 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: got cnt %0d busy %b want cnt 3 busy 0", frame_cnt, busy);
    end
  endtask

  task automatic test_mode_change();
    @(posedge clk);
    #1 mode = 2'd2;
    en = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        tests_run++;
        if (dut_vec !== exp_out(f == 0 ? 2 : 1, model_fc, c)) begin
          tests_failed++;
          $display("FAIL modechg f%0d off %0d: got %h want %h", f, c, dut_vec,
                   exp_out(f == 0 ? 2 : 1, model_fc, c));
        end
        if (f == 0 && c == 100) mode = 2'd1;
        if (f == 1 && c == 50) en = 1'b0;
      end
      model_fc++;
    end
    @(negedge clk);
    tests_run++;
    if (dut_vec !== idle_out(model_fc)) begin
      tests_failed++;
      $display("FAIL modechg_idle: got %h want %h", dut_vec, idle_out(model_fc));
    end
  endtask

  task automatic test_random_frames();
    int m;
    @(posedge clk);
    #1 mode = 2'($urandom_range(3, 0));
    m = int'(mode);
    en = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        tests_run++;
        if (dut_vec !== exp_out(m, model_fc, c)) begin
          tests_failed++;
          $display("FAIL rand f%0d m%0d off %0d: got %h want %h", f, m, c, dut_vec,
                   exp_out(m, model_fc, c));
        end
        if ($urandom_range(15, 0) == 0) mode = 2'($urandom_range(3, 0));
        if (f == 3 && c == 20) en = 1'b0;
        if (c == FRAME - 1) m = int'(mode);
      end
      model_fc++;
    end
    @(negedge clk);
    tests_run++;
    if (dut_vec !== idle_out(model_fc)) begin
      tests_failed++;
      $display("FAIL rand_idle: got %h want %h", dut_vec, idle_out(model_fc));
    end
  endtask

  task automatic test_rst_mid_frame();
    int m;
    int stop_at;
    stop_at = (VS + VBP + 2) * HT + 7;
    @(posedge clk);
    #1 mode = 2'($urandom_range(3, 0));
    m = int'(mode);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int c = 0; c <= stop_at; c++) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== exp_out(m, model_fc, c)) begin
        tests_failed++;
        $display("FAIL rstmid off %0d: got %h want %h", c, dut_vec, exp_out(m, model_fc, c));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_fc = 0;
    tests_run++;
    if (dut_vec !== 29'd0) begin
      tests_failed++;
      $display("FAIL rstmid_clear: got %h want %h", dut_vec, 29'd0);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== idle_out(0)) begin
        tests_failed++;
        $display("FAIL rstmid_after cyc %0d: got %h want %h", i, dut_vec, idle_out(0));
      end
    end
  endtask

  task automatic test_en_drop_vbp();
    int m;
    bit phase;
    logic [7:0] hi;
    logic [11:0] got [$];
    logic [11:0] want;
    phase = 1'b0;
    hi = 8'h00;
    @(posedge clk);
    #1 mode = 2'($urandom_range(3, 0));
    m = int'(mode);
    en = 1'b1;
    @(posedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== exp_out(m, model_fc, c)) begin
        tests_failed++;
        $display("FAIL endrop off %0d: got %h want %h", c, dut_vec, exp_out(m, model_fc, c));
      end
      if (href) begin
        if (!phase) hi = data;
        else got.push_back({hi[3:0], data});
        phase = ~phase;
      end
      if (c == VS * HT + 3) en = 1'b0;
    end
    tests_run++;
    if (got.size() != W * AH) begin
      tests_failed++;
      $display("FAIL loopback_count: got %0d want %0d", got.size(), W * AH);
    end else begin
      for (int y = 0; y < AH; y++) begin
        for (int x = 0; x < W; x++) begin
          want = ref_rgb(m, x, y, model_fc + y * W + x);
          tests_run++;
          if (got[y * W + x] !== want) begin
            tests_failed++;
            $display("FAIL loopback px %0d,%0d: got %h want %h", x, y, got[y * W + x], want);
          end
        end
      end
    end
    model_fc++;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (dut_vec !== idle_out(model_fc)) begin
        tests_failed++;
        $display("FAIL endrop_idle: got %h want %h", dut_vec, idle_out(model_fc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_bars_single();
    test_back_to_back();
    test_mode_change();
    test_random_frames();
    test_rst_mid_frame();
    test_en_drop_vbp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
